// File: rtl/lsu_pkg.sv
// lsu_pkg
// Constants and state encoding for the load/store unit. The data memory and
// the execute stage import the same package so widths and depth stay in sync.
//   DATA_W    : data width, one memory word
//   ADDR_W    : memory word address width
//   EA_W      : width of base, offset and effective address
//   MEM_DEPTH : number of words in the data memory
//   lsu_state_e : IDLE / ACCESS / RESP
package lsu_pkg;

   localparam int DATA_W    = 8;
   localparam int ADDR_W    = 5;
   localparam int EA_W      = 8;
   localparam int MEM_DEPTH = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } lsu_state_e;

endpackage

// File: rtl/lsu_addr_gen.sv
// lsu_addr_gen
// Combinational effective-address adder and range check.
//   base      : unsigned base address (EA_W bits)
//   offset    : two's complement offset (EA_W bits)
//   word_addr : low ADDR_W bits of the effective address
//   fault     : effective address lies outside the memory
// Optional feature: macro LSU_FAULT_EN enables the range check. Without it,
// fault is constant 0 and addresses alias modulo MEM_DEPTH.
module lsu_addr_gen
   import lsu_pkg::*;
(
   input  logic [EA_W-1:0]   base,
   input  logic [EA_W-1:0]   offset,
   output logic [ADDR_W-1:0] word_addr,
   output logic              fault
);

   logic [EA_W-1:0] ea;

   // Plain EA_W-bit add: a negative offset is just its two's complement
   // bit pattern, and the carry out is dropped so 0xFF + 0x02 wraps to 0x01.
   always_comb begin
      ea = base + offset;
   end

   assign word_addr = ea[ADDR_W-1:0];

`ifdef LSU_FAULT_EN
   // Any set bit above the word address means the access is past the end
   // of the 32-word memory.
   assign fault = |ea[EA_W-1:ADDR_W];
`else
   // High address bits are intentionally dropped (aliasing mod 32).
   logic unused_high_bits;
   assign unused_high_bits = |ea[EA_W-1:ADDR_W];
   assign fault            = 1'b0;
`endif

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit
// Memory-access stage between execute and the 32x8 data memory. Takes one
// load/store per valid/ready handshake, spends one cycle driving the memory
// and returns a response held under backpressure.
//   Clk, Reset        : clock, synchronous active-low reset
//   Req_*             : request handshake, write flag, base, offset, store data
//   Resp_*            : response handshake, load data, fault flag
//   Mem_addr/Mem_data_in/Mem_en : memory address, write data, write strobe
//   Mem_data_out      : combinational read data from the memory
// Optional feature: macro LSU_FAULT_EN (out-of-range accesses fault).
module load_store_unit
   import lsu_pkg::*;
(
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Req_valid,
   output logic              Req_ready,
   input  logic              Req_write,
   input  logic [EA_W-1:0]   Req_base,
   input  logic [EA_W-1:0]   Req_offset,
   input  logic [DATA_W-1:0] Req_wdata,
   output logic              Resp_valid,
   input  logic              Resp_ready,
   output logic [DATA_W-1:0] Resp_rdata,
   output logic              Resp_fault,
   output logic [ADDR_W-1:0] Mem_addr,
   output logic [DATA_W-1:0] Mem_data_in,
   output logic              Mem_en,
   input  logic [DATA_W-1:0] Mem_data_out
);

   lsu_state_e        state_q, state_d;
   logic              write_q, write_d;
   logic              pend_fault_q, pend_fault_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
   logic              mem_en_q, mem_en_d;
   logic              resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              fault_q, fault_d;

   logic [ADDR_W-1:0] gen_addr;
   logic              gen_fault;
   logic              req_accept;

   lsu_addr_gen u_addr_gen (
      .base      (Req_base),
      .offset    (Req_offset),
      .word_addr (gen_addr),
      .fault     (gen_fault)
   );

   // Ready only while idle and out of reset, so nothing is accepted in the
   // same cycle a reset is being applied.
   assign req_accept = Req_valid && Req_ready;

   // Next-state logic. Memory port values are captured on the accept edge so
   // they are already valid for the whole ACCESS cycle; the write strobe is
   // raised only for an in-range store and dropped again on leaving ACCESS.
   always_comb begin
      state_d       = state_q;
      write_d       = write_q;
      pend_fault_d  = pend_fault_q;
      mem_addr_d    = mem_addr_q;
      mem_data_in_d = mem_data_in_q;
      mem_en_d      = 1'b0;
      resp_valid_d  = resp_valid_q;
      rdata_d       = rdata_q;
      fault_d       = fault_q;
      case (state_q)
         IDLE: begin
            if (req_accept) begin
               state_d      = ACCESS;
               write_d      = Req_write;
               pend_fault_d = gen_fault;
               mem_addr_d   = gen_addr;
               mem_en_d     = Req_write && !gen_fault;
               if (Req_write) begin
                  mem_data_in_d = Req_wdata;
               end
            end
         end
         ACCESS: begin
            // Stores and faulted accesses return zero data.
            state_d      = RESP;
            resp_valid_d = 1'b1;
            fault_d      = pend_fault_q;
            rdata_d      = (write_q || pend_fault_q) ? '0 : Mem_data_out;
         end
         RESP: begin
            if (Resp_ready) begin
               state_d      = IDLE;
               resp_valid_d = 1'b0;
            end
         end
         default: begin
            state_d      = IDLE;
            resp_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset drops any in-flight request and
   // clears every registered output.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q       <= IDLE;
         write_q       <= 1'b0;
         pend_fault_q  <= 1'b0;
         mem_addr_q    <= '0;
         mem_data_in_q <= '0;
         mem_en_q      <= 1'b0;
         resp_valid_q  <= 1'b0;
         rdata_q       <= '0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         write_q       <= write_d;
         pend_fault_q  <= pend_fault_d;
         mem_addr_q    <= mem_addr_d;
         mem_data_in_q <= mem_data_in_d;
         mem_en_q      <= mem_en_d;
         resp_valid_q  <= resp_valid_d;
         rdata_q       <= rdata_d;
         fault_q       <= fault_d;
      end
   end

   // Reset gates the strobe directly so a reset arriving during a store's
   // ACCESS cycle keeps the memory from being written at that edge.
   assign Mem_en      = mem_en_q && Reset;
   assign Req_ready   = (state_q == IDLE) && Reset;
   assign Mem_addr    = mem_addr_q;
   assign Mem_data_in = mem_data_in_q;
   assign Resp_valid  = resp_valid_q;
   assign Resp_rdata  = rdata_q;
   assign Resp_fault  = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Drives load_store_unit against a behavioural 32x8 memory and compares
// every response with a reference model that keeps its own copy of memory.
module tb_load_store_unit;

`ifdef LSU_FAULT_EN
   localparam bit FAULT_EN = 1'b1;
`else
   localparam bit FAULT_EN = 1'b0;
`endif

   logic       Clk, Reset;
   logic       Req_valid, Req_ready, Req_write;
   logic [7:0] Req_base, Req_offset, Req_wdata;
   logic       Resp_valid, Resp_ready, Resp_fault;
   logic [7:0] Resp_rdata;
   logic [4:0] Mem_addr;
   logic [7:0] Mem_data_in, Mem_data_out;
   logic       Mem_en;

   logic [7:0] tb_mem  [32];
   logic [7:0] ref_mem [32];
   logic       mem_init;

   int total = 0;
   int bad   = 0;

   logic       obs_timeout, obs_acc_ready, obs_acc_valid, obs_valid, obs_fault;
   logic       obs_stable, obs_post_valid, obs_post_ready;
   logic [4:0] obs_acc_addr;
   logic [7:0] obs_acc_data, obs_rdata;
   int         obs_mem_en_cycles;

   load_store_unit dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .Req_valid    (Req_valid),
      .Req_ready    (Req_ready),
      .Req_write    (Req_write),
      .Req_base     (Req_base),
      .Req_offset   (Req_offset),
      .Req_wdata    (Req_wdata),
      .Resp_valid   (Resp_valid),
      .Resp_ready   (Resp_ready),
      .Resp_rdata   (Resp_rdata),
      .Resp_fault   (Resp_fault),
      .Mem_addr     (Mem_addr),
      .Mem_data_in  (Mem_data_in),
      .Mem_en       (Mem_en),
      .Mem_data_out (Mem_data_out)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   function automatic logic [7:0] init_val(input int i);
      if (i == 4) return 8'hFF;
      return 8'(i * 4);
   endfunction

   // Behavioural data memory: combinational read, write on Mem_en.
   assign Mem_data_out = tb_mem[Mem_addr];
   always @(posedge Clk) begin
      if (mem_init) begin
         for (int i = 0; i < 32; i++) tb_mem[i] <= init_val(i);
      end else if (Mem_en) begin
         tb_mem[Mem_addr] <= Mem_data_in;
      end
   end

   // Reference model: effective address is base plus signed offset modulo
   // 256; out-of-range addresses fault only when the feature is built in.
   task automatic model_txn(input logic wr, input logic [7:0] base, input logic [7:0] off,
                            input logic [7:0] wd, output logic [4:0] e_addr,
                            output logic [7:0] e_rdata, output logic e_fault,
                            output int e_writes);
      int ea;
      ea       = ((int'(base) + int'($signed(off))) % 256 + 256) % 256;
      e_addr   = 5'(ea % 32);
      e_fault  = FAULT_EN && (ea >= 32);
      e_rdata  = 8'h00;
      e_writes = 0;
      if (!e_fault) begin
         if (wr) begin
            ref_mem[ea % 32] = wd;
            e_writes = 1;
         end else begin
            e_rdata = ref_mem[ea % 32];
         end
      end
   endtask

   // Runs one complete transaction and records what the DUT did in each
   // phase; stall is the number of extra RESP cycles with Resp_ready low.
   task automatic applyStimulus(input logic wr, input logic [7:0] base, input logic [7:0] off,
                                input logic [7:0] wd, input int stall);
      int waits;
      obs_timeout       = 1'b0;
      obs_mem_en_cycles = 0;
      obs_stable        = 1'b1;
      @(negedge Clk);
      Req_valid  = 1'b1;
      Req_write  = wr;
      Req_base   = base;
      Req_offset = off;
      Req_wdata  = wd;
      waits = 0;
      while (!Req_ready && waits < 10) begin
         @(negedge Clk);
         waits++;
      end
      if (!Req_ready) begin
         obs_timeout = 1'b1;
         Req_valid   = 1'b0;
         return;
      end
      @(posedge Clk);
      @(negedge Clk);
      Req_valid  = 1'b0;
      Req_write  = 1'($urandom);
      Req_base   = 8'($urandom);
      Req_offset = 8'($urandom);
      Req_wdata  = 8'($urandom);
      if (Mem_en) obs_mem_en_cycles++;
      obs_acc_addr  = Mem_addr;
      obs_acc_data  = Mem_data_in;
      obs_acc_ready = Req_ready;
      obs_acc_valid = Resp_valid;
      @(negedge Clk);
      obs_valid = Resp_valid;
      obs_rdata = Resp_rdata;
      obs_fault = Resp_fault;
      for (int k = 0; k < stall; k++) begin
         if (Mem_en) obs_mem_en_cycles++;
         if (Resp_valid !== 1'b1 || Resp_rdata !== obs_rdata || Resp_fault !== obs_fault ||
             Req_ready !== 1'b0) obs_stable = 1'b0;
         @(negedge Clk);
      end
      if (Mem_en) obs_mem_en_cycles++;
      Resp_ready = 1'b1;
      @(negedge Clk);
      Resp_ready = 1'b0;
      obs_post_valid = Resp_valid;
      obs_post_ready = Req_ready;
   endtask

   // Reset clears every output and holds Req_ready low.
   task automatic test_reset();
      @(negedge Clk);
      Reset     = 1'b0;
      Req_valid = 1'b1;
      @(negedge Clk);
      total++; if (Req_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_req_ready: got %b expected 0", Req_ready); end
      total++; if (Resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", Resp_valid); end
      total++; if (Mem_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_en: got %b expected 0", Mem_en); end
      total++; if (Mem_addr !== 5'h00) begin bad++; $display("[TB] FAIL reset_mem_addr: got %h expected 00", Mem_addr); end
      total++; if (Mem_data_in !== 8'h00) begin bad++; $display("[TB] FAIL reset_mem_data_in: got %h expected 00", Mem_data_in); end
      total++; if (Resp_rdata !== 8'h00) begin bad++; $display("[TB] FAIL reset_rdata: got %h expected 00", Resp_rdata); end
      total++; if (Resp_fault !== 1'b0) begin bad++; $display("[TB] FAIL reset_fault: got %b expected 0", Resp_fault); end
      Req_valid = 1'b0;
      Reset     = 1'b1;
      #1;
      total++; if (Req_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_release_ready: got %b expected 1", Req_ready); end
   endtask

   // Directed transactions: the spec examples plus the wrap and range edge.
   task automatic test_directed();
      logic       t_wr    [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [7:0] t_base  [8] = '{8'h01, 8'h10, 8'h10, 8'h05, 8'hFF, 8'h1F, 8'h00, 8'h1F};
      logic [7:0] t_off   [8] = '{8'h00, 8'h02, 8'h02, 8'hFF, 8'h02, 8'h01, 8'h00, 8'h00};
      logic [7:0] t_wd    [8] = '{8'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h00};
      logic [4:0] e_addr;
      logic [7:0] e_rdata;
      logic       e_fault;
      int         e_writes;
      for (int i = 0; i < 8; i++) begin
         model_txn(t_wr[i], t_base[i], t_off[i], t_wd[i], e_addr, e_rdata, e_fault, e_writes);
         applyStimulus(t_wr[i], t_base[i], t_off[i], t_wd[i], 0);
         total++; if (obs_timeout) begin bad++; $display("[TB] FAIL dir%0d_accept: got timeout expected accept", i); end
         if (!obs_timeout) begin
            total++; if (obs_acc_addr !== e_addr) begin bad++; $display("[TB] FAIL dir%0d_mem_addr: got %h expected %h", i, obs_acc_addr, e_addr); end
            total++; if (obs_mem_en_cycles != e_writes) begin bad++; $display("[TB] FAIL dir%0d_mem_en: got %0d expected %0d", i, obs_mem_en_cycles, e_writes); end
            if (e_writes == 1) begin
               total++; if (obs_acc_data !== t_wd[i]) begin bad++; $display("[TB] FAIL dir%0d_mem_data: got %h expected %h", i, obs_acc_data, t_wd[i]); end
            end
            total++; if (obs_acc_ready !== 1'b0 || obs_acc_valid !== 1'b0) begin bad++; $display("[TB] FAIL dir%0d_access_flags: got ready=%b valid=%b expected 0 0", i, obs_acc_ready, obs_acc_valid); end
            total++; if (obs_valid !== 1'b1) begin bad++; $display("[TB] FAIL dir%0d_resp_valid: got %b expected 1", i, obs_valid); end
            total++; if (obs_rdata !== e_rdata) begin bad++; $display("[TB] FAIL dir%0d_rdata: got %h expected %h", i, obs_rdata, e_rdata); end
            total++; if (obs_fault !== e_fault) begin bad++; $display("[TB] FAIL dir%0d_fault: got %b expected %b", i, obs_fault, e_fault); end
            total++; if (obs_post_valid !== 1'b0 || obs_post_ready !== 1'b1) begin bad++; $display("[TB] FAIL dir%0d_release: got valid=%b ready=%b expected 0 1", i, obs_post_valid, obs_post_ready); end
         end
      end
   endtask

   // Response held for three cycles with Resp_ready low.
   task automatic test_backpressure();
      logic [4:0] e_addr;
      logic [7:0] e_rdata;
      logic       e_fault;
      int         e_writes;
      model_txn(1'b0, 8'h04, 8'h00, 8'h00, e_addr, e_rdata, e_fault, e_writes);
      applyStimulus(1'b0, 8'h04, 8'h00, 8'h00, 3);
      total++; if (obs_timeout) begin bad++; $display("[TB] FAIL bp_accept: got timeout expected accept"); end
      total++; if (obs_stable !== 1'b1) begin bad++; $display("[TB] FAIL bp_stable: got %b expected 1", obs_stable); end
      total++; if (obs_rdata !== e_rdata) begin bad++; $display("[TB] FAIL bp_rdata: got %h expected %h", obs_rdata, e_rdata); end
      total++; if (obs_post_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_release: got %b expected 0", obs_post_valid); end
   endtask

   // Reset during a store's ACCESS cycle suppresses the write and the response.
   task automatic test_reset_in_access();
      logic [7:0] wd;
      logic [4:0] e_addr;
      logic [7:0] e_rdata;
      logic       e_fault;
      int         e_writes;
      int         waits;
      int         late_valid;
      wd = ~ref_mem[7];
      @(negedge Clk);
      Req_valid = 1'b1; Req_write = 1'b1; Req_base = 8'h07; Req_offset = 8'h00; Req_wdata = wd;
      waits = 0;
      while (!Req_ready && waits < 10) begin @(negedge Clk); waits++; end
      total++; if (!Req_ready) begin bad++; $display("[TB] FAIL rst_acc_accept: got timeout expected accept"); end
      @(posedge Clk);
      @(negedge Clk);
      Req_valid = 1'b0;
      Reset     = 1'b0;
      #1;
      total++; if (Mem_en !== 1'b0) begin bad++; $display("[TB] FAIL rst_acc_mem_en: got %b expected 0", Mem_en); end
      @(negedge Clk);
      total++; if (Resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_acc_resp_valid: got %b expected 0", Resp_valid); end
      Reset = 1'b1;
      #1;
      total++; if (Req_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_acc_idle: got %b expected 1", Req_ready); end
      late_valid = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge Clk);
         if (Resp_valid !== 1'b0) late_valid++;
      end
      total++; if (late_valid != 0) begin bad++; $display("[TB] FAIL rst_acc_no_resp: got %0d valid cycles expected 0", late_valid); end
      model_txn(1'b0, 8'h07, 8'h00, 8'h00, e_addr, e_rdata, e_fault, e_writes);
      applyStimulus(1'b0, 8'h07, 8'h00, 8'h00, 0);
      total++; if (obs_rdata !== e_rdata) begin bad++; $display("[TB] FAIL rst_acc_mem_kept: got %h expected %h", obs_rdata, e_rdata); end
   endtask

   // Continuous requests with a ready consumer: one accept every 3 cycles.
   task automatic test_back_to_back();
      int accepts;
      accepts = 0;
      @(negedge Clk);
      Req_valid = 1'b1; Req_write = 1'b0; Req_base = 8'h02; Req_offset = 8'h00;
      Resp_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         if (k > 0) @(negedge Clk);
         if (Req_ready) accepts++;
      end
      Req_valid = 1'b0;
      @(negedge Clk);
      Resp_ready = 1'b0;
      total++; if (accepts != 4) begin bad++; $display("[TB] FAIL b2b_accepts: got %0d expected 4", accepts); end
      total++; if (Req_ready !== 1'b1 || Resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_drain: got ready=%b valid=%b expected 1 0", Req_ready, Resp_valid); end
   endtask

   // Random loads and stores with random backpressure.
   task automatic test_random();
      logic       wr;
      logic [7:0] base, off, wd;
      int         stall;
      logic [4:0] e_addr;
      logic [7:0] e_rdata;
      logic       e_fault;
      int         e_writes;
      for (int i = 0; i < 40; i++) begin
         wr    = 1'($urandom);
         base  = (i % 2 == 0) ? 8'($urandom_range(0, 31)) : 8'($urandom);
         off   = (i % 2 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
         wd    = 8'($urandom);
         stall = $urandom_range(0, 2);
         model_txn(wr, base, off, wd, e_addr, e_rdata, e_fault, e_writes);
         applyStimulus(wr, base, off, wd, stall);
         total++;
         if (obs_timeout || obs_acc_addr !== e_addr || obs_mem_en_cycles != e_writes ||
             (e_writes == 1 && obs_acc_data !== wd) || obs_valid !== 1'b1 ||
             obs_rdata !== e_rdata || obs_fault !== e_fault || obs_stable !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rand%0d: got to=%b addr=%h we=%0d data=%h v=%b rd=%h f=%b st=%b expected addr=%h we=%0d data=%h v=1 rd=%h f=%b st=1",
                     i, obs_timeout, obs_acc_addr, obs_mem_en_cycles, obs_acc_data, obs_valid,
                     obs_rdata, obs_fault, obs_stable, e_addr, e_writes, wd, e_rdata, e_fault);
         end
      end
   endtask

   initial begin
      Reset = 1'b0; Req_valid = 1'b0; Req_write = 1'b0;
      Req_base = 8'h00; Req_offset = 8'h00; Req_wdata = 8'h00; Resp_ready = 1'b0;
      mem_init = 1'b1;
      for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      mem_init = 1'b0;
      $display("[TB] starting load_store_unit bench, fault check %0d", FAULT_EN);
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_in_access();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
